alu_fu_dispatch: RTL and testbench

//   Downstream consumer of the ALU reservation-station lines. Round-robin picks one ready line,

---
 rtl/alu_fu_dispatch_pkg.sv | 29 ++
 rtl/alu_fu_dispatch_core.sv | 31 +++
 rtl/alu_fu_dispatch.sv | 187 ++++++++++++++++++
 tb/tb_alu_fu_dispatch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_fu_dispatch_pkg.sv
// Shared definitions for the ALU functional-unit dispatcher: ALU op codes,
// CDB field widths and the dispatcher FSM state encoding.
package alu_fu_dispatch_pkg;

    localparam int unsigned CDB_W  = 41;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_CDB = 2'd2
    } fu_state_e;

endpackage

// File: rtl/alu_fu_dispatch_core.sv
// Purely combinational 32-bit ALU used by alu_fu_dispatch.
// Wrap-around arithmetic, no flags; shifts use b[4:0]; unknown ops give 0.
module alu_core
    import alu_fu_dispatch_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Result mux over the supported operations
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_AND:    y = a & b;
            ALU_OR:     y = a | b;
            ALU_XOR:    y = a ^ b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:    y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   y = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/alu_fu_dispatch.sv
// ALU functional-unit dispatcher: round-robin picks a ready RS line, runs it
// through a fixed-latency ALU, holds the result until the CDB grant, then
// pulses that line's result_taken.
// Optional: define ALU_FU_PERF_EN to add perf_busy_cycles / perf_cdb_stall.
module alu_fu_dispatch
    import alu_fu_dispatch_pkg::*;
#(
    parameter int unsigned NUM_RS   = 3,
    parameter int unsigned LATENCY  = 1,
    parameter logic [7:0]  TAG_BASE = 8'h01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RS-1:0]      rs_ready,
    input  logic [4*NUM_RS-1:0]    rs_alu_ctrl,
    input  logic [32*NUM_RS-1:0]   rs_v1,
    input  logic [32*NUM_RS-1:0]   rs_v2,
    output logic [NUM_RS-1:0]      rs_result_taken,
    output logic                   cdb_req,
    input  logic                   cdb_grant,
    output logic [CDB_W-1:0]       cdb_out,
    output logic                   fu_busy
`ifdef ALU_FU_PERF_EN
    ,
    output logic [31:0]            perf_busy_cycles,
    output logic [31:0]            perf_cdb_stall
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_RS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (NUM_RS < 2 || NUM_RS > 8) begin : g_bad_num_rs
        $error("alu_fu_dispatch: NUM_RS must be 2..8");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("alu_fu_dispatch: LATENCY must be >= 1");
    end
    if (32'(TAG_BASE) + NUM_RS - 1 > 255) begin : g_bad_tag
        $error("alu_fu_dispatch: TAG_BASE+NUM_RS-1 wraps past 8'hFF");
    end

    fu_state_e         state_q,   state_d;
    logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]  sel_idx_q, sel_idx_d;
    logic [3:0]        op_q,      op_d;
    logic [DATA_W-1:0] v1_q,      v1_d;
    logic [DATA_W-1:0] v2_q,      v2_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] alu_y;

    // base and off are both below NUM_RS, so one subtraction is enough
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_RS) s = s - NUM_RS;
        return IDX_W'(s);
    endfunction

    alu_core u_alu_core (
        .op (op_q),
        .a  (v1_q),
        .b  (v2_q),
        .y  (alu_y)
    );

    // Round-robin pick: first ready line scanning from rr_ptr upward
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (!pick_found && rs_ready[wrap_add(rr_ptr_q, i)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr_q, i);
            end
        end
    end

    // FSM next-state and operand/result latching
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_idx_d = sel_idx_q;
        op_d      = op_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_idx_d = pick_idx;
                    op_d      = rs_alu_ctrl[32'(pick_idx)*4 +: 4];
                    v1_d      = rs_v1[32'(pick_idx)*32 +: 32];
                    v2_d      = rs_v2[32'(pick_idx)*32 +: 32];
                    cnt_d     = CNT_W'(LATENCY - 1);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = alu_y;
                    state_d  = ST_WAIT_CDB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_CDB: begin
                if (cdb_grant) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (32'(sel_idx_q) == NUM_RS - 1) ? '0 : sel_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CDB drive and result_taken pulse, active only while waiting for the bus
    always_comb begin
        cdb_req         = 1'b0;
        cdb_out         = '0;
        rs_result_taken = '0;
        fu_busy         = (state_q != ST_IDLE);
        if (state_q == ST_WAIT_CDB) begin
            cdb_req = 1'b1;
            cdb_out = {1'b1, TAG_BASE + TAG_W'(sel_idx_q), result_q};
            if (cdb_grant) rs_result_taken[sel_idx_q] = 1'b1;
        end
    end

    // State registers; async reset drops any in-flight op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            sel_idx_q <= '0;
            op_q      <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_idx_q <= sel_idx_d;
            op_q      <= op_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ALU_FU_PERF_EN
    logic [31:0] busy_cnt_q,  busy_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating busy / bus-stall counters
    always_comb begin
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fu_busy && busy_cnt_q != '1) busy_cnt_d = busy_cnt_q + 1'b1;
        if (state_q == ST_WAIT_CDB && !cdb_grant && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_busy_cycles = busy_cnt_q;
    assign perf_cdb_stall   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_fu_dispatch.sv
// Self-checking bench for alu_fu_dispatch (NUM_RS=3, TAG_BASE=1).
// Main instance uses LATENCY=1; a second LATENCY=3 instance shares the inputs
// and is examined only for the asynchronous-reset scenario.
module tb_alu_fu_dispatch;

    localparam logic [7:0] TB_TAG_BASE = 8'h01;

    typedef struct packed {
        logic [2:0]  taken;
        logic [40:0] cdb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rs_ready;
    logic [11:0] rs_alu_ctrl;
    logic [95:0] rs_v1, rs_v2;
    logic        cdb_grant;

    logic [2:0]  rs_result_taken, taken3;
    logic        cdb_req, req3;
    logic [40:0] cdb_out, out3;
    logic        fu_busy, busy3;
`ifdef ALU_FU_PERF_EN
    logic [31:0] perf_busy_cycles, perf_cdb_stall, pbusy3, pstall3;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_fu_dispatch #(.NUM_RS(3), .LATENCY(1), .TAG_BASE(TB_TAG_BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_ready        (rs_ready),
        .rs_alu_ctrl     (rs_alu_ctrl),
        .rs_v1           (rs_v1),
        .rs_v2           (rs_v2),
        .rs_result_taken (rs_result_taken),
        .cdb_req         (cdb_req),
        .cdb_grant       (cdb_grant),
        .cdb_out         (cdb_out),
        .fu_busy         (fu_busy)
`ifdef ALU_FU_PERF_EN
        ,
        .perf_busy_cycles(perf_busy_cycles),
        .perf_cdb_stall  (perf_cdb_stall)
`endif
    );

    alu_fu_dispatch #(.NUM_RS(3), .LATENCY(3), .TAG_BASE(TB_TAG_BASE)) dut3 (
        .clk             (clk),
        .rst             (rst),
        .rs_ready        (rs_ready),
        .rs_alu_ctrl     (rs_alu_ctrl),
        .rs_v1           (rs_v1),
        .rs_v2           (rs_v2),
        .rs_result_taken (taken3),
        .cdb_req         (req3),
        .cdb_grant       (cdb_grant),
        .cdb_out         (out3),
        .fu_busy         (busy3)
`ifdef ALU_FU_PERF_EN
        ,
        .perf_busy_cycles(pbusy3),
        .perf_cdb_stall  (pstall3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] mk_cdb(input int line, input logic [31:0] data);
        logic [7:0] tag;
        tag = TB_TAG_BASE + 8'(line);
        return {1'b1, tag, data};
    endfunction

    task automatic set_line(input int line, input logic [3:0] ctrl,
                            input logic [31:0] a, input logic [31:0] b);
        rs_alu_ctrl[4*line +: 4] = ctrl;
        rs_v1[32*line +: 32]     = a;
        rs_v2[32*line +: 32]     = b;
    endtask

    task automatic push_exp(input int line, input logic [31:0] data);
        exp_t e;
        e.taken = 3'(1 << line);
        e.cdb   = mk_cdb(line, data);
        q.push_back(e);
    endtask

    // Waits (bounded) for a granted broadcast on the main DUT and scores it
    task automatic expect_bcast(input string tag, output int cyc);
        exp_t e;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cdb_req && cdb_grant) begin
                cyc = i;
                break;
            end
        end
        if (q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(cdb_req), 64'(0));
        end else begin
            e = q.pop_front();
            if (cyc < 0) begin
                check({tag, "_timeout"}, 64'(cdb_req), 64'(1));
            end else begin
                check({tag, "_cdb"}, 64'(cdb_out), 64'(e.cdb));
                check({tag, "_taken"}, 64'(rs_result_taken), 64'(e.taken));
            end
        end
    endtask

    task automatic run_op(input string tag, input int line, input logic [3:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        int cyc;
        set_line(line, ctrl, a, b);
        rs_ready = 3'(1 << line);
        push_exp(line, res);
        expect_bcast(tag, cyc);
        rs_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   seen;
        exp_t e;

        rst         = 1'b0;
        rs_ready    = '0;
        rs_alu_ctrl = '0;
        rs_v1       = '0;
        rs_v2       = '0;
        cdb_grant   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy",  64'(fu_busy), 64'(0));
        check("rst_req",   64'(cdb_req), 64'(0));
        check("rst_cdb",   64'(cdb_out), 64'(0));
        check("rst_taken", 64'(rs_result_taken), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Single ADD on line 1 with grant tied high
        cdb_grant = 1'b1;
        set_line(1, 4'd0, 32'd5, 32'd7);
        rs_ready = 3'b010;
        push_exp(1, 32'd12);
        expect_bcast("t1_add", cyc);
        check("t1_latency", 64'(cyc), 64'(2));
        rs_ready = '0;
        @(negedge clk);
        check("t1_busy_drop", 64'(fu_busy), 64'(0));
        check("t1_taken_drop", 64'(rs_result_taken), 64'(0));

        // Grant while IDLE / EXEC is ignored
        check("t6_idle_taken", 64'(rs_result_taken), 64'(0));
        check("t6_idle_cdb", 64'(cdb_out), 64'(0));
        set_line(0, 4'd4, 32'hAAAA_0000, 32'h0000_5555);
        rs_ready = 3'b001;
        push_exp(0, 32'hAAAA_5555);
        @(negedge clk);
        check("t6_exec_busy", 64'(fu_busy), 64'(1));
        check("t6_exec_taken", 64'(rs_result_taken), 64'(0));
        check("t6_exec_req", 64'(cdb_req), 64'(0));
        expect_bcast("t6_xor", cyc);
        rs_ready = '0;
        @(negedge clk);

        // Round-robin over all three lines, wrapping 2 -> 0
        do_reset();
        set_line(0, 4'd0, 32'd10, 32'd20);
        set_line(1, 4'd1, 32'd100, 32'd1);
        set_line(2, 4'd4, 32'h0000_F0F0, 32'h0000_0FF0);
        rs_ready = 3'b111;
        push_exp(0, 32'd30);
        push_exp(1, 32'd99);
        push_exp(2, 32'h0000_FF00);
        push_exp(0, 32'd30);
        expect_bcast("t2_rr0", cyc);
        expect_bcast("t2_rr1", cyc);
        expect_bcast("t2_rr2", cyc);
        expect_bcast("t2_rr0_wrap", cyc);
        rs_ready = '0;
        @(negedge clk);

        // ALU corner cases
        run_op("t3_sub_wrap", 0, 4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF);
        run_op("t3_sra_31",   1, 4'd7,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
        run_op("t3_slt",      2, 4'd8,  32'hFFFF_FFFF, 32'd1,         32'd1);
        run_op("t3_sltu",     0, 4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0);
        run_op("t3_undef",    1, 4'hF,  32'h1234,      32'h5678,      32'd0);
        run_op("t3_and",      2, 4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        run_op("t3_or",       0, 4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
        run_op("t3_sll_mask", 1, 4'd5,  32'd1,         32'h21,        32'd2);
        run_op("t3_srl",      2, 4'd6,  32'h8000_0000, 32'd31,        32'd1);
        run_op("t3_passb",    0, 4'd10, 32'hDEAD,      32'hCAFE_BABE, 32'hCAFE_BABE);
        run_op("t3_add_wrap", 1, 4'd0,  32'hFFFF_FFFF, 32'd2,         32'd1);
        run_op("t3_sra_pos",  2, 4'd7,  32'h4000_0000, 32'd4,         32'h0400_0000);
        @(negedge clk);

        // Grant withheld for five cycles in WAIT_CDB
        cdb_grant = 1'b0;
        set_line(1, 4'd0, 32'd3, 32'd4);
        rs_ready = 3'b010;
        push_exp(1, 32'd7);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cdb_req) begin
                cyc = i;
                break;
            end
        end
        rs_ready = '0;
        check("t4_req_seen", 64'(cdb_req), 64'(1));
        e = q.pop_front();
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_req", 64'(cdb_req), 64'(1));
            check("t4_hold_cdb", 64'(cdb_out), 64'(e.cdb));
            check("t4_hold_taken", 64'(rs_result_taken), 64'(0));
            @(negedge clk);
        end
        cdb_grant = 1'b1;
        #1;
        check("t4_grant_taken", 64'(rs_result_taken), 64'(e.taken));
        check("t4_grant_cdb", 64'(cdb_out), 64'(e.cdb));
`ifdef ALU_FU_PERF_EN
        check("t4_perf_stall", 64'(perf_cdb_stall), 64'(5));
`endif
        @(negedge clk);
        cdb_grant = 1'b0;
        #1;
        check("t4_single_pulse", 64'(rs_result_taken), 64'(0));
        check("t4_idle_req", 64'(cdb_req), 64'(0));
        check("t4_idle_busy", 64'(fu_busy), 64'(0));

        // Async reset mid-EXEC on the LATENCY=3 instance
        @(negedge clk);
        do_reset();
        cdb_grant = 1'b1;
        set_line(2, 4'd0, 32'd9, 32'd9);
        rs_ready = 3'b100;
        repeat (2) @(negedge clk);
        check("t5_busy_before", 64'(busy3), 64'(1));
        #2;
        rst = 1'b0;
        rs_ready = '0;
        #1;
        check("t5_rst_busy", 64'(busy3), 64'(0));
        check("t5_rst_req", 64'(req3), 64'(0));
        check("t5_rst_cdb", 64'(out3), 64'(0));
        check("t5_rst_taken", 64'(taken3), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (req3) seen = 1;
        end
        check("t5_no_bcast", 64'(seen), 64'(0));
        set_line(0, 4'd0, 32'd1, 32'd2);
        rs_ready = 3'b101;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req3) begin
                cyc = i;
                break;
            end
        end
        check("t5_first_cdb", 64'(out3), 64'(mk_cdb(0, 32'd3)));
        check("t5_first_taken", 64'(taken3), 64'(3'b001));
        check("t5_latency", 64'(cyc), 64'(4));
        rs_ready = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
